// File: rtl/coin_payout_hopper.sv
// coin_payout_hopper: turns a credit amount into timed hopper pulses, counts sensed coins, faults on a jam
module coin_payout_hopper #(
    parameter int AMT_W          = 5,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             coin_sense,
    input  logic             fault_clr,
    output logic             coin_pulse,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] paid_count
);
    localparam int TMAX = (TIMEOUT_CYCLES > PULSE_CYCLES) ?
                          ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) :
                          ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, GAP, DONE, FAULT} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    sync;
    logic          sense_rise;

    assign sense_rise = sync[1] & ~sync[2];

    // two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync <= '0;
        else         sync <= {sync[1:0], coin_sense};
    end

    // payout sequencer with registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            timer      <= '0;
            req_ready  <= 1'b1;
            coin_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            remaining  <= '0;
            paid_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        paid_count <= '0;
                        timer      <= '0;
                        if (req_amount == '0) begin
                            remaining <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            remaining  <= req_amount;
                            coin_pulse <= 1'b1;
                            state      <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    if (timer == TW'(PULSE_CYCLES - 1)) begin
                        coin_pulse <= 1'b0;
                        timer      <= '0;
                        state      <= WAIT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT: begin
                    if (sense_rise) begin
                        timer <= '0;
                        if (remaining != '0) begin
                            remaining  <= remaining - AMT_W'(1);
                            paid_count <= paid_count + AMT_W'(1);
                        end
                        if (remaining <= AMT_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer      <= '0;
                        coin_pulse <= 1'b1;
                        state      <= PULSE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault     <= 1'b0;
                        remaining <= '0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
